cpu_debug_ctrl: RTL and testbench

- Run-control and trace block for the 16-bit single-cycle CPU.
- Gates the CPU through a clock enable (cpu_en) and supports run, stop and single-step, with NUM_BP PC breakpoints.
- Records control-flow instructions (jump or taken branch) into a circular trace buffer and counts executed cycles.
- Sits between the bench or debug host and the CPU top. Generalises the fixed free-running run/halt of the current CPU.

---
 rtl/cpu_dbg_pkg.sv | 26 ++
 rtl/dbg_trace_buf.sv | 58 +++++
 rtl/cpu_debug_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu_debug_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings for the CPU run-control / trace block: command opcodes,
// run states and stop causes.
package cpu_dbg_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_RUN       = 3'd1;
  localparam logic [2:0] OP_STOP      = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_SET_BP    = 3'd4;
  localparam logic [2:0] OP_CLR_BP    = 3'd5;
  localparam logic [2:0] OP_CLR_TRACE = 3'd6;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STEP    = 2'd2,
    ST_HALTED  = 2'd3
  } run_state_t;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_STOP = 3'd1;
  localparam logic [2:0] CAUSE_BP   = 3'd2;
  localparam logic [2:0] CAUSE_HALT = 3'd3;
  localparam logic [2:0] CAUSE_STEP = 3'd4;

endpackage

// File: rtl/dbg_trace_buf.sv
// Circular control-flow trace buffer: keeps the newest TRACE_DEPTH captures,
// flags overwrites, and reads back oldest-first through a combinational mux.
module dbg_trace_buf #(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic                           clr,
  input  logic [ADDR_W-1:0]              wr_pc,
  input  logic [INSTR_W-1:0]             wr_instr,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [ADDR_W-1:0]              rd_pc,
  output logic [INSTR_W-1:0]             rd_instr,
  output logic [$clog2(TRACE_DEPTH):0]   count,
  output logic                           ovf
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(TRACE_DEPTH);

  logic [ADDR_W-1:0]  mem_pc    [TRACE_DEPTH];
  logic [INSTR_W-1:0] mem_instr [TRACE_DEPTH];
  logic [PTR_W-1:0]   wp;
  logic [PTR_W-1:0]   rd_ptr;

  // A clear in the same cycle as a capture drops that capture.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem_pc[wp]    <= wr_pc;
      mem_instr[wp] <= wr_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (wr_en) begin
      wp <= wp + PTR_W'(1);
      if (count == FULL) ovf <= 1'b1;
      else count <= count + (PTR_W+1)'(1);
    end
  end

  // When full, count's low bits are zero so the oldest entry sits at wp.
  assign rd_ptr   = wp - count[PTR_W-1:0] + rd_idx;
  assign rd_pc    = mem_pc[rd_ptr];
  assign rd_instr = mem_instr[rd_ptr];

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run-control and trace block for the 16-bit single-cycle CPU: run/stop/step
// through a clock enable, PC breakpoints, control-flow trace and cycle counter.
module cpu_debug_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int INSTR_W     = 16,
  parameter int NUM_BP      = 4,
  parameter int TRACE_DEPTH = 8,
  parameter int CYCLE_W     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [2:0]                     cmd_op,
  input  logic [2:0]                     cmd_idx,
  input  logic [ADDR_W-1:0]              cmd_addr,
  input  logic [ADDR_W-1:0]              cpu_pc,
  input  logic [INSTR_W-1:0]             cpu_instr,
  input  logic                           cpu_halt,
  input  logic                           cpu_jump,
  input  logic                           cpu_branch_taken,
  output logic                           cpu_en,
  output logic [1:0]                     run_state,
  output logic [2:0]                     stop_cause,
  output logic [CYCLE_W-1:0]             cycle_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [ADDR_W-1:0]              trace_pc,
  output logic [INSTR_W-1:0]             trace_instr,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_ovf
);

  run_state_t        state;
  logic              skip_bp;
  logic [NUM_BP-1:0] bp_match;
  logic              bp_hit;
  logic              cmd_fire;

  assign cmd_ready = (state != ST_STEP);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign bp_hit    = (state == ST_RUNNING) && !skip_bp && (|bp_match);
  assign cpu_en    = ((state == ST_RUNNING) && !bp_hit) || (state == ST_STEP);
  assign run_state = state;

  // Indices at or above NUM_BP match no comparator and are silently ignored.
  for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_en;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        bp_addr <= '0;
        bp_en   <= 1'b0;
      end else if (cmd_fire && cmd_idx == 3'(i)) begin
        if (cmd_op == OP_SET_BP) begin
          bp_addr <= cmd_addr;
          bp_en   <= 1'b1;
        end else if (cmd_op == OP_CLR_BP) begin
          bp_en <= 1'b0;
        end
      end
    end

    assign bp_match[i] = bp_en && (bp_addr == cpu_pc);
  end

  // Halt outranks a breakpoint, which outranks a STOP command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_STOPPED;
      stop_cause <= CAUSE_NONE;
      skip_bp    <= 1'b0;
    end else begin
      if (cpu_en) skip_bp <= 1'b0;
      unique case (state)
        ST_RUNNING: begin
          if (cpu_en && cpu_halt) begin
            state      <= ST_HALTED;
            stop_cause <= CAUSE_HALT;
          end else if (bp_hit) begin
            state      <= ST_STOPPED;
            stop_cause <= CAUSE_BP;
          end else if (cmd_fire && cmd_op == OP_STOP) begin
            state      <= ST_STOPPED;
            stop_cause <= CAUSE_STOP;
          end
        end
        ST_STEP: begin
          state      <= cpu_halt ? ST_HALTED : ST_STOPPED;
          stop_cause <= cpu_halt ? CAUSE_HALT : CAUSE_STEP;
        end
        default: begin
          if (cmd_fire && cmd_op == OP_RUN) begin
            state      <= ST_RUNNING;
            stop_cause <= CAUSE_NONE;
            skip_bp    <= 1'b1;
          end else if (cmd_fire && cmd_op == OP_STEP) begin
            state <= ST_STEP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_count <= '0;
    else if (cpu_en && !(&cycle_count)) cycle_count <= cycle_count + CYCLE_W'(1);
  end

  dbg_trace_buf #(
    .ADDR_W      (ADDR_W),
    .INSTR_W     (INSTR_W),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cpu_en && (cpu_jump || cpu_branch_taken)),
    .clr      (cmd_fire && cmd_op == OP_CLR_TRACE),
    .wr_pc    (cpu_pc),
    .wr_instr (cpu_instr),
    .rd_idx   (trace_rd_idx),
    .rd_pc    (trace_pc),
    .rd_instr (trace_instr),
    .count    (trace_count),
    .ovf      (trace_ovf)
  );

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Bench for cpu_debug_ctrl: a tiny program-driven CPU stand-in, directed
// scenarios with hand-computed expectations, and a randomized model run.
module tb_cpu_debug_ctrl;
  import cpu_dbg_pkg::*;

  localparam int AW = 16, IW = 16, NBP = 4, TD = 8, CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0, cmd_idx = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cpu_pc;
  logic [IW-1:0] cpu_instr;
  logic          cpu_halt, cpu_jump, cpu_branch_taken, cpu_en;
  logic [1:0]    run_state;
  logic [2:0]    stop_cause;
  logic [CW-1:0] cycle_count;
  logic [2:0]    trace_rd_idx = '0;
  logic [AW-1:0] trace_pc;
  logic [IW-1:0] trace_instr;
  logic [3:0]    trace_count;
  logic          trace_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_debug_ctrl #(.ADDR_W(AW), .INSTR_W(IW), .NUM_BP(NBP), .TRACE_DEPTH(TD), .CYCLE_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_addr(cmd_addr), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
    .cpu_halt(cpu_halt), .cpu_jump(cpu_jump), .cpu_branch_taken(cpu_branch_taken),
    .cpu_en(cpu_en), .run_state(run_state), .stop_cause(stop_cause), .cycle_count(cycle_count),
    .trace_rd_idx(trace_rd_idx), .trace_pc(trace_pc), .trace_instr(trace_instr),
    .trace_count(trace_count), .trace_ovf(trace_ovf)
  );

  // CPU stand-in: a 64-entry program of decoded control bits, PC gated by cpu_en.
  logic          prog_halt [64];
  logic          prog_jump [64];
  logic          prog_br   [64];
  logic [15:0]   prog_tgt  [64];
  logic [15:0]   prog_instr[64];
  logic [15:0]   pc;
  int            en_total = 0;

  assign cpu_pc           = pc;
  assign cpu_instr        = prog_instr[pc[5:0]];
  assign cpu_halt         = prog_halt[pc[5:0]];
  assign cpu_jump         = prog_jump[pc[5:0]];
  assign cpu_branch_taken = prog_br[pc[5:0]];

  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else if (cpu_en) begin
      en_total <= en_total + 1;
      if (!cpu_halt) pc <= (cpu_jump || cpu_branch_taken) ? prog_tgt[pc[5:0]] : pc + 16'd1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_program();
    for (int i = 0; i < 64; i++) begin
      prog_halt[i] = 1'b0; prog_jump[i] = 1'b0; prog_br[i] = 1'b0;
      prog_tgt[i] = '0; prog_instr[i] = 16'h1000 + 16'(i);
    end
  endtask

  task automatic load_seq();
    clear_program();
    prog_halt[5] = 1'b1;
  endtask

  task automatic load_chain();
    clear_program();
    for (int i = 0; i < 10; i++) begin prog_br[i] = 1'b1; prog_tgt[i] = 16'(i + 1); end
    prog_halt[10] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [15:0] addr);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_addr = addr;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic wait_stopped();
    for (int k = 0; k < 40 && run_state == 2'd1; k++) @(negedge clk);
  endtask

  task automatic wait_pc(input logic [15:0] target);
    for (int k = 0; k < 20 && cpu_pc != target; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    clear_program();
    @(negedge clk);
    reset = 1'b0;
    #2;
    n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL reset_cpu_en got=%0b exp=0", cpu_en); end
    n_checks++; if (run_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got=%0d exp=0", run_state); end
    n_checks++; if (stop_cause !== 3'd0) begin n_errors++; $display("FAIL reset_cause got=%0d exp=0", stop_cause); end
    n_checks++; if (cycle_count !== '0) begin n_errors++; $display("FAIL reset_cycles got=%0d exp=0", cycle_count); end
    n_checks++; if (trace_count !== 4'd0 || trace_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_trace got=%0d/%0b exp=0/0", trace_count, trace_ovf); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got=%0b exp=1", cmd_ready); end
  endtask

  task automatic test_run_to_halt();
    int e0;
    load_seq();
    do_reset();
    e0 = en_total;
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_stopped();
    n_checks++; if (run_state !== 2'd3) begin n_errors++; $display("FAIL halt_state got=%0d exp=3", run_state); end
    n_checks++; if (stop_cause !== CAUSE_HALT) begin n_errors++; $display("FAIL halt_cause got=%0d exp=3", stop_cause); end
    n_checks++; if (cycle_count !== CW'(6)) begin n_errors++; $display("FAIL halt_cycles got=%0d exp=6", cycle_count); end
    n_checks++; if (en_total - e0 !== 6) begin n_errors++; $display("FAIL halt_en_pulses got=%0d exp=6", en_total - e0); end
    n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL halt_cpu_en got=%0b exp=0", cpu_en); end
  endtask

  task automatic test_breakpoint();
    load_seq();
    do_reset();
    send_cmd(OP_SET_BP, 3'd5, 16'd2);
    send_cmd(OP_SET_BP, 3'd0, 16'd3);
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_stopped();
    n_checks++; if (run_state !== 2'd0) begin n_errors++; $display("FAIL bp_state got=%0d exp=0", run_state); end
    n_checks++; if (stop_cause !== CAUSE_BP) begin n_errors++; $display("FAIL bp_cause got=%0d exp=2", stop_cause); end
    n_checks++; if (cpu_pc !== 16'd3) begin n_errors++; $display("FAIL bp_pc got=%0d exp=3", cpu_pc); end
    n_checks++; if (cycle_count !== CW'(3)) begin n_errors++; $display("FAIL bp_cycles got=%0d exp=3", cycle_count); end
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_stopped();
    n_checks++; if (run_state !== 2'd3 || stop_cause !== CAUSE_HALT) begin n_errors++; $display("FAIL bp_resume got=%0d/%0d exp=3/3", run_state, stop_cause); end
    n_checks++; if (cycle_count !== CW'(6)) begin n_errors++; $display("FAIL bp_resume_cycles got=%0d exp=6", cycle_count); end
  endtask

  task automatic test_step();
    int e0;
    load_seq();
    do_reset();
    send_cmd(OP_SET_BP, 3'd0, 16'd1);
    for (int s = 0; s < 3; s++) begin
      e0 = en_total;
      send_cmd(OP_STEP, 3'd0, 16'd0);
      n_checks++; if (run_state !== 2'd2 || cmd_ready !== 1'b0) begin n_errors++; $display("FAIL step%0d_busy got=%0d/%0b exp=2/0", s, run_state, cmd_ready); end
      @(posedge clk); @(negedge clk);
      n_checks++; if (en_total - e0 !== 1) begin n_errors++; $display("FAIL step%0d_pulses got=%0d exp=1", s, en_total - e0); end
      n_checks++; if (run_state !== 2'd0 || stop_cause !== CAUSE_STEP) begin n_errors++; $display("FAIL step%0d_done got=%0d/%0d exp=0/4", s, run_state, stop_cause); end
    end
    n_checks++; if (cpu_pc !== 16'd3) begin n_errors++; $display("FAIL step_pc got=%0d exp=3", cpu_pc); end
    send_cmd(OP_CLR_BP, 3'd0, 16'd0);
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_stopped();
    e0 = en_total;
    send_cmd(OP_STEP, 3'd0, 16'd0);
    @(posedge clk); @(negedge clk);
    n_checks++; if (run_state !== 2'd3 || stop_cause !== CAUSE_HALT) begin n_errors++; $display("FAIL step_halt got=%0d/%0d exp=3/3", run_state, stop_cause); end
    n_checks++; if (en_total - e0 !== 1) begin n_errors++; $display("FAIL step_halt_pulses got=%0d exp=1", en_total - e0); end
  endtask

  task automatic test_trace();
    load_chain();
    do_reset();
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_stopped();
    n_checks++; if (run_state !== 2'd3) begin n_errors++; $display("FAIL trace_run got=%0d exp=3", run_state); end
    n_checks++; if (trace_count !== 4'd8 || trace_ovf !== 1'b1) begin n_errors++; $display("FAIL trace_full got=%0d/%0b exp=8/1", trace_count, trace_ovf); end
    for (int r = 0; r < 8; r++) begin
      trace_rd_idx = 3'(r);
      #1;
      n_checks++; if (trace_pc !== 16'(r + 2) || trace_instr !== 16'h1000 + 16'(r + 2)) begin
        n_errors++; $display("FAIL trace_entry%0d got=%0h/%0h exp=%0h/%0h", r, trace_pc, trace_instr, r + 2, 16'h1000 + 16'(r + 2));
      end
    end
    send_cmd(OP_CLR_TRACE, 3'd0, 16'd0);
    n_checks++; if (trace_count !== 4'd0 || trace_ovf !== 1'b0) begin n_errors++; $display("FAIL trace_clear got=%0d/%0b exp=0/0", trace_count, trace_ovf); end
  endtask

  task automatic test_stop_priority();
    load_seq();
    do_reset();
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_pc(16'd2);
    send_cmd(OP_STOP, 3'd0, 16'd0);
    n_checks++; if (run_state !== 2'd0 || stop_cause !== CAUSE_STOP) begin n_errors++; $display("FAIL stop_plain got=%0d/%0d exp=0/1", run_state, stop_cause); end
    n_checks++; if (cycle_count !== CW'(3)) begin n_errors++; $display("FAIL stop_plain_cycles got=%0d exp=3", cycle_count); end
    do_reset();
    send_cmd(OP_SET_BP, 3'd1, 16'd2);
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_pc(16'd2);
    send_cmd(OP_STOP, 3'd0, 16'd0);
    n_checks++; if (run_state !== 2'd0 || stop_cause !== CAUSE_BP) begin n_errors++; $display("FAIL stop_vs_bp got=%0d/%0d exp=0/2", run_state, stop_cause); end
    n_checks++; if (cycle_count !== CW'(2)) begin n_errors++; $display("FAIL stop_vs_bp_cycles got=%0d exp=2", cycle_count); end
    do_reset();
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_pc(16'd5);
    send_cmd(OP_STOP, 3'd0, 16'd0);
    n_checks++; if (run_state !== 2'd3 || stop_cause !== CAUSE_HALT) begin n_errors++; $display("FAIL stop_vs_halt got=%0d/%0d exp=3/3", run_state, stop_cause); end
    n_checks++; if (cycle_count !== CW'(6)) begin n_errors++; $display("FAIL stop_vs_halt_cycles got=%0d exp=6", cycle_count); end
  endtask

  task automatic test_async_reset();
    load_chain();
    do_reset();
    send_cmd(OP_SET_BP, 3'd0, 16'd7);
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_pc(16'd4);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (cpu_en !== 1'b0) begin n_errors++; $display("FAIL areset_cpu_en got=%0b exp=0", cpu_en); end
    n_checks++; if (run_state !== 2'd0 || stop_cause !== 3'd0) begin n_errors++; $display("FAIL areset_state got=%0d/%0d exp=0/0", run_state, stop_cause); end
    n_checks++; if (cycle_count !== '0) begin n_errors++; $display("FAIL areset_cycles got=%0d exp=0", cycle_count); end
    n_checks++; if (trace_count !== 4'd0 || trace_ovf !== 1'b0) begin n_errors++; $display("FAIL areset_trace got=%0d/%0b exp=0/0", trace_count, trace_ovf); end
    #2;
    reset = 1'b1;
    @(negedge clk);
    send_cmd(OP_RUN, 3'd0, 16'd0);
    wait_stopped();
    n_checks++; if (run_state !== 2'd3 || cycle_count !== CW'(11)) begin n_errors++; $display("FAIL areset_bp_cleared got=%0d/%0d exp=3/11", run_state, cycle_count); end
  endtask

  task automatic test_random();
    int          m_state, m_cause, rd;
    int unsigned m_cyc;
    bit          m_skip, m_ovf, valid, ready, fire, hit, en, cap;
    bit          m_bpen[8];
    logic [15:0] m_bpa[8];
    logic [31:0] m_tr[$];
    logic [15:0] m_pc, addr;
    logic [2:0]  op, idx;
    logic [5:0]  a;
    int          r;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 99);
      prog_instr[i] = 16'($urandom);
      prog_halt[i] = (r < 5);
      prog_jump[i] = (r >= 5 && r < 15);
      prog_br[i] = (r >= 15 && r < 27);
      prog_tgt[i] = 16'($urandom_range(0, 63));
    end
    do_reset();
    m_state = 0; m_cause = 0; m_cyc = 0; m_skip = 0; m_ovf = 0; m_pc = '0; m_tr.delete();
    for (int b = 0; b < 8; b++) begin m_bpen[b] = 0; m_bpa[b] = '0; end
    for (int t = 0; t < 800; t++) begin
      valid = ($urandom_range(0, 3) == 0);
      op = 3'($urandom_range(0, 7)); idx = 3'($urandom_range(0, 7)); addr = 16'($urandom_range(0, 63));
      cmd_valid = valid; cmd_op = op; cmd_idx = idx; cmd_addr = addr;
      a = m_pc[5:0];
      ready = (m_state != 2);
      fire = valid && ready;
      hit = 0;
      if (m_state == 1 && !m_skip)
        for (int b = 0; b < NBP; b++) if (m_bpen[b] && m_bpa[b] == m_pc) hit = 1;
      en = (m_state == 1 && !hit) || (m_state == 2);
      #1;
      n_checks++; if (cpu_en !== en) begin n_errors++; $display("FAIL rnd%0d_cpu_en got=%0b exp=%0b", t, cpu_en, en); end
      n_checks++; if (cmd_ready !== ready) begin n_errors++; $display("FAIL rnd%0d_ready got=%0b exp=%0b", t, cmd_ready, ready); end
      @(posedge clk);
      cap = en && (prog_jump[a] || prog_br[a]);
      if (fire && op == OP_CLR_TRACE) begin
        m_tr.delete(); m_ovf = 0;
      end else if (cap) begin
        m_tr.push_back({m_pc, prog_instr[a]});
        if (m_tr.size() > TD) begin void'(m_tr.pop_front()); m_ovf = 1; end
      end
      if (en) begin
        if (m_cyc < CMAX) m_cyc++;
        m_skip = 0;
      end
      if (fire && op == OP_SET_BP && idx < NBP) begin m_bpen[idx] = 1; m_bpa[idx] = addr; end
      if (fire && op == OP_CLR_BP && idx < NBP) m_bpen[idx] = 0;
      case (m_state)
        1: begin
          if (en && prog_halt[a]) begin m_state = 3; m_cause = 3; end
          else if (hit) begin m_state = 0; m_cause = 2; end
          else if (fire && op == OP_STOP) begin m_state = 0; m_cause = 1; end
        end
        2: begin
          if (prog_halt[a]) begin m_state = 3; m_cause = 3; end
          else begin m_state = 0; m_cause = 4; end
        end
        default: begin
          if (fire && op == OP_RUN) begin m_state = 1; m_cause = 0; m_skip = 1; end
          else if (fire && op == OP_STEP) m_state = 2;
        end
      endcase
      if (en && !prog_halt[a]) m_pc = (prog_jump[a] || prog_br[a]) ? prog_tgt[a] : m_pc + 16'd1;
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++; if (run_state !== 2'(m_state) || stop_cause !== 3'(m_cause)) begin n_errors++; $display("FAIL rnd%0d_state got=%0d/%0d exp=%0d/%0d", t, run_state, stop_cause, m_state, m_cause); end
      n_checks++; if (cycle_count !== CW'(m_cyc)) begin n_errors++; $display("FAIL rnd%0d_cycles got=%0d exp=%0d", t, cycle_count, m_cyc); end
      n_checks++; if (trace_count !== 4'(m_tr.size()) || trace_ovf !== m_ovf) begin n_errors++; $display("FAIL rnd%0d_trace got=%0d/%0b exp=%0d/%0b", t, trace_count, trace_ovf, m_tr.size(), m_ovf); end
      if (m_tr.size() > 0) begin
        rd = $urandom_range(0, m_tr.size() - 1);
        trace_rd_idx = 3'(rd);
        #1;
        n_checks++; if ({trace_pc, trace_instr} !== m_tr[rd]) begin n_errors++; $display("FAIL rnd%0d_entry%0d got=%0h exp=%0h", t, rd, {trace_pc, trace_instr}, m_tr[rd]); end
      end
    end
  endtask

  initial begin
    $display("[TB] cpu_debug_ctrl bench start");
    test_reset();
    test_run_to_halt();
    test_breakpoint();
    test_step();
    test_trace();
    test_stop_priority();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
